// File: rtl/alu_muldiv.sv
// Iterative HI/LO multiply/divide unit, one radix-2 step per cycle (shift-add multiply, restoring divide).
// Latency: Mul/Div accept at edge N -> HI/LO written and done high from edge N+DATA_W+1; Mthi/Mtlo write at the accept edge.
// Backpressure: in_ready low during CALC/FIX; the requester holds in_valid until it sees the accept.
// Ports: clock, reset_n (async, active-low); in_valid/in_ready/in_op/in_a/in_b request channel;
//        rd_sel/rd_valid/rd_data HI (rd_sel=1) or LO read port; done is a one-cycle pulse with the Mul/Div commit.
// Option: define ALU_MULDIV_EARLY_OUT_EN to let multiplies jump to FIX once the remaining multiplier bits are zero.
module alu_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              rd_sel,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done
);

  localparam logic [2:0] OP_MULU = 3'd0;
  localparam logic [2:0] OP_MULS = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_DIVS = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] hi, lo;
  // acc: product high half / partial remainder; qr: multiplier (shifting out) / quotient (shifting in)
  logic [DATA_W-1:0] acc, qr, md;
  logic [CNT_W-1:0]  cnt;
  logic              is_div, neg_lo, neg_hi, div_zero;

  logic              accept, calc_last;
  logic              op_signed, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;

  // Gate on state directly so accept does not depend on the FSM output process.
  assign accept    = in_valid & (state == IDLE);
  assign op_signed = (in_op == OP_MULS) || (in_op == OP_DIVS);
  assign a_neg     = op_signed & in_a[DATA_W-1];
  assign b_neg     = op_signed & in_b[DATA_W-1];
  // Most-negative input maps to itself, which is the correct unsigned magnitude.
  assign a_mag     = a_neg ? -in_a : in_a;
  assign b_mag     = b_neg ? -in_b : in_b;

  assign rd_data   = rd_sel ? hi : lo;

  // One iteration of either algorithm.
  logic [DATA_W:0]   mul_sum, div_shift;
  logic [DATA_W-1:0] acc_step, qr_step;

  always_comb begin
    mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, md} : '0);
    div_shift = {acc, qr[DATA_W-1]};
    acc_step  = '0;
    qr_step   = '0;
    if (is_div) begin
      if (div_shift >= {1'b0, md}) begin
        acc_step = DATA_W'(div_shift - {1'b0, md});
        qr_step  = {qr[DATA_W-2:0], 1'b1};
      end else begin
        acc_step = div_shift[DATA_W-1:0];
        qr_step  = {qr[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_step = mul_sum[DATA_W:1];
      qr_step  = {mul_sum[0], qr[DATA_W-1:1]};
    end
  end

  // Sign correction applied in FIX. A zero divisor leaves acc = |a|, so re-applying the
  // dividend sign returns in_a unchanged in HI; the quotient is forced to all ones.
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod     = {acc, qr};
    prod_fix = neg_lo ? -prod : prod;
    fix_hi   = prod_fix[2*DATA_W-1:DATA_W];
    fix_lo   = prod_fix[DATA_W-1:0];
    if (is_div) begin
      fix_hi = neg_hi ? -acc : acc;
      fix_lo = div_zero ? '1 : (neg_lo ? -qr : qr);
    end
  end

`ifdef ALU_MULDIV_EARLY_OUT_EN
  // Unprocessed multiplier bits sit in qr[cnt-1:0]; once they are zero every remaining
  // step is a plain right shift, so apply all of them at once.
  logic                early_out;
  logic [2*DATA_W-1:0] prod_align;
  assign early_out  = (state == CALC) && !is_div && ((qr & ~({DATA_W{1'b1}} << cnt)) == '0);
  assign prod_align = {acc, qr} >> cnt;
  assign calc_last  = (cnt == CNT_W'(1)) || early_out;
`else
  assign calc_last  = (cnt == CNT_W'(1));
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        rd_valid = 1'b1;
        if (accept && (in_op <= OP_DIVS)) state_nxt = CALC;
      end
      CALC:    if (calc_last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      qr       <= '0;
      md       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Pulse lands on the same edge that writes HI/LO.
      done <= (state == FIX);
      case (state)
        IDLE: if (accept) begin
          case (in_op)
            OP_MTHI: hi <= in_a;
            OP_MTLO: lo <= in_a;
            OP_MULU, OP_MULS: begin
              acc      <= '0;
              qr       <= b_mag;
              md       <= a_mag;
              is_div   <= 1'b0;
              neg_lo   <= a_neg ^ b_neg;
              neg_hi   <= 1'b0;
              div_zero <= 1'b0;
              cnt      <= CNT_W'(DATA_W);
            end
            OP_DIVU, OP_DIVS: begin
              acc      <= '0;
              qr       <= a_mag;
              md       <= b_mag;
              is_div   <= 1'b1;
              neg_lo   <= a_neg ^ b_neg;
              neg_hi   <= a_neg;
              div_zero <= (in_b == '0);
              cnt      <= CNT_W'(DATA_W);
            end
            default: ;
          endcase
        end
        CALC: begin
`ifdef ALU_MULDIV_EARLY_OUT_EN
          if (early_out) begin
            {acc, qr} <= prod_align;
            cnt       <= '0;
          end else
`endif
          begin
            acc <= acc_step;
            qr  <= qr_step;
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases plus random ops against a plain-arithmetic model.
// Latency: each op waits for its done pulse within a bounded number of cycles.
// Backpressure: requests are held until in_ready is seen, including a request held across a busy unit.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         rd_sel = 1'b0;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         done;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_muldiv #(.DATA_W(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .rd_sel   (rd_sel),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    rd_sel = 1'b1;
    #1 chk({tag, "_hi"}, rd_data, m_hi);
    rd_sel = 1'b0;
    #1 chk({tag, "_lo"}, rd_data, m_lo);
  endtask

  // Architectural result {HI, LO} from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, rm;
    logic [2*W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = {m_hi, m_lo};
    case (op)
      3'd0: r = {32'd0, a} * {32'd0, b};
      3'd1: r = sa * sb;
      3'd2: r = (b == '0) ? {a, {W{1'b1}}} : {a % b, a / b};
      3'd3: begin
        if (b == '0) r = {a, {W{1'b1}}};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[W-1:0], q[W-1:0]};
        end
      end
      3'd4: r = {a, m_lo};
      3'd5: r = {m_hi, a};
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [2*W-1:0] exp;
    int lat;
    int guard;
    exp = ref_op(op, a, b);
    @(negedge clock);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    chk1({tag, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    rd_sel   = 1'b1;
    #1 chk({tag, "_same_cycle_rd"}, rd_data, m_hi);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    if (op <= 3'd3) begin
      chk1({tag, "_busy_rd_valid"}, rd_valid, 1'b0);
      #1 chk({tag, "_busy_rd"}, rd_data, m_hi);
      lat = 0;
      while (!done && lat < 100) begin
        @(negedge clock);
        lat++;
      end
      chk1({tag, "_done"}, done, 1'b1);
`ifdef ALU_MULDIV_EARLY_OUT_EN
      if (op <= 3'd1) chk1({tag, "_lat"}, (lat >= 2 && lat <= W + 1), 1'b1); else
`endif
      chk({tag, "_lat"}, W'(lat), W'(W + 1));
      chk1({tag, "_rd_valid"}, rd_valid, 1'b1);
      m_hi = exp[2*W-1:W];
      m_lo = exp[W-1:0];
      chk_regs(tag);
      @(negedge clock);
      chk1({tag, "_done_pulse"}, done, 1'b0);
    end else begin
      chk1({tag, "_no_done"}, done, 1'b0);
      chk1({tag, "_idle"}, in_ready, 1'b1);
      m_hi = exp[2*W-1:W];
      m_lo = exp[W-1:0];
      chk_regs(tag);
    end
  endtask

  initial begin
    logic [2*W-1:0] exp1;
    logic [2:0]     rop;
    logic [W-1:0]   ra, rb;
    int             lat;
    bit             saw;

    // Reset state
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_rd_valid", rd_valid, 1'b1);
    chk1("reset_done", done, 1'b0);
    chk_regs("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Directed corners
    run_op(3'd1, 32'hFFFFFFFD, 32'd5, "muls_neg");
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulu_max");
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, "divs_neg");
    run_op(3'd2, 32'd100, 32'd0, "divu_by0");
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, "divs_ovf");
    run_op(3'd3, 32'hFFFFFFF9, 32'd0, "divs_by0");
    run_op(3'd1, 32'h80000000, 32'h80000000, "muls_minmin");
    run_op(3'd0, 32'd7, 32'd1, "mulu_small");
    run_op(3'd1, 32'd12345, 32'd0, "muls_zero");
    run_op(3'd5, 32'hA5A5A5A5, 32'd0, "mtlo");
    run_op(3'd6, 32'h11111111, 32'h22222222, "rsvd6");
    run_op(3'd7, 32'h33333333, 32'h44444444, "rsvd7");
    run_op(3'd4, 32'h12345678, 32'd0, "mthi");

    // Request held across a busy unit: second op taken only after the first done
    @(negedge clock);
    in_valid = 1'b1;
    in_op    = 3'd2;
    in_a     = 32'd1000;
    in_b     = 32'd7;
    exp1     = ref_op(3'd2, 32'd1000, 32'd7);
    @(posedge clock);
    @(negedge clock);
    in_a   = 32'hDEADBEEF;
    in_b   = 32'h00000010;
    rd_sel = 1'b1;
    chk1("held_busy_rd_valid", rd_valid, 1'b0);
    #1 chk("held_busy_rd", rd_data, 32'h12345678);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    chk1("held_first_done", done, 1'b1);
    chk("held_first_lat", W'(lat), W'(W + 1));
    m_hi = exp1[2*W-1:W];
    m_lo = exp1[W-1:0];
    exp1 = ref_op(3'd2, 32'hDEADBEEF, 32'h00000010);
    @(negedge clock);
    in_valid = 1'b0;
    chk1("held_second_taken", in_ready, 1'b0);
    chk1("held_done_pulse", done, 1'b0);
    chk_regs("held_first_result");
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    chk1("held_second_done", done, 1'b1);
    chk("held_second_lat", W'(lat), W'(W + 1));
    m_hi = exp1[2*W-1:W];
    m_lo = exp1[W-1:0];
    chk_regs("held_second_result");

    // Reset ten cycles into a multiply aborts it
    @(negedge clock);
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_a     = 32'd3;
    in_b     = 32'd4;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    m_hi    = '0;
    m_lo    = '0;
    #1;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_rd_valid", rd_valid, 1'b1);
    chk1("abort_done", done, 1'b0);
    chk_regs("abort");
    @(negedge clock);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw = 1'b1;
    end
    chk1("abort_no_done", saw, 1'b0);
    chk_regs("abort_after");
    run_op(3'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, "post_reset_muls");

    // Random ops against the model
    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: if ($urandom_range(0, 1) == 0) rb = -rb;
        default: ;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
